// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per clock, valid/ready on both sides; WIDTH edges from accept to result.
// Define SERIAL_DIVIDER_SIGNED_EN to add the op_signed input for two's-complement operation.
module serial_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SERIAL_DIVIDER_SIGNED_EN
  input  logic             op_signed,
`endif
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo_q, rem_q, dvsr_q;
  logic             zero_q;
  logic             qneg_q, rneg_q;
  logic             accept, last_iter, fits;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] quo_nxt, rem_nxt, quo_fin, rem_fin;
  logic [WIDTH-1:0] dnd_mag, dvs_mag;
  logic             dnd_neg, dvs_neg;

  assign accept    = start_valid && start_ready;
  // A zero divisor spends a single BUSY cycle, so DONE follows the accept edge by one edge.
  assign last_iter = (state == BUSY) && (zero_q || (cnt == CW'(WIDTH - 1)));

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
    fits    = ~trial[WIDTH];
    rem_nxt = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], fits};
    quo_fin = qneg_q ? (~quo_nxt + 1'b1) : quo_nxt;
    rem_fin = rneg_q ? (~rem_nxt + 1'b1) : rem_nxt;
  end

`ifdef SERIAL_DIVIDER_SIGNED_EN
  assign dnd_neg = op_signed && dividend[WIDTH-1];
  assign dvs_neg = op_signed && divisor[WIDTH-1];
`else
  assign dnd_neg = 1'b0;
  assign dvs_neg = 1'b0;
`endif
  assign dnd_mag = dnd_neg ? (~dividend + 1'b1) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)       state_nxt = BUSY;
      BUSY:    if (last_iter)    state_nxt = DONE;
      DONE:    if (result_ready) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_ready  = (state == IDLE);
    result_valid = (state == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvsr_q      <= '0;
      zero_q      <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt         <= '0;
      rem_q       <= '0;
      dvsr_q      <= dvs_mag;
      zero_q      <= (divisor == '0);
      // Raw dividend is kept for divide-by-zero so the remainder returns it unchanged.
      quo_q       <= (divisor == '0) ? dividend : dnd_mag;
      qneg_q      <= dnd_neg ^ dvs_neg;
      rneg_q      <= dnd_neg;
      div_by_zero <= 1'b0;
    end else if (state == BUSY) begin
      if (zero_q) begin
        quo_q       <= '1;
        rem_q       <= quo_q;
        div_by_zero <= 1'b1;
      end else begin
        cnt   <= last_iter ? '0 : cnt + 1'b1;
        quo_q <= last_iter ? quo_fin : quo_nxt;
        rem_q <= last_iter ? rem_fin : rem_nxt;
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_serial_divider.sv
// Directed bench for serial_divider at WIDTH=32; signed vectors run only when SERIAL_DIVIDER_SIGNED_EN is defined.
module tb_serial_divider;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start_valid, start_ready;
  logic [W-1:0] dividend, divisor;
  logic         result_valid, result_ready;
  logic [W-1:0] quotient, remainder;
  logic         div_by_zero;
`ifdef SERIAL_DIVIDER_SIGNED_EN
  logic         op_signed;
`endif

  int vectors     = 0;
  int miscompares = 0;

  serial_divider #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .dividend     (dividend),
    .divisor      (divisor),
`ifdef SERIAL_DIVIDER_SIGNED_EN
    .op_signed    (op_signed),
`endif
    .result_valid (result_valid),
    .result_ready (result_ready),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge with the divider idle; returns at #1 after the accept edge.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend    = a;
    divisor     = b;
    start_valid = 1'b1;
    @(posedge clock); #1;
    start_valid = 1'b0;
    chk("accepted", {63'd0, start_ready}, 64'd0);
  endtask

  task automatic wait_result(input string tag, input int exp_edges, input logic [W-1:0] q,
                             input logic [W-1:0] r, input logic dz);
    int edges;
    edges = 0;
    while (!result_valid && edges < 100) begin
      @(posedge clock); #1;
      edges++;
    end
    chk({tag, " latency"}, 64'(edges), 64'(exp_edges));
    chk({tag, " quotient"}, 64'(quotient), 64'(q));
    chk({tag, " remainder"}, 64'(remainder), 64'(r));
    chk({tag, " div_by_zero"}, {63'd0, div_by_zero}, {63'd0, dz});
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    @(posedge clock); #1;
    result_ready = 1'b0;
    chk("idle after handshake", {62'd0, start_ready, result_valid}, 64'b10);
  endtask

  initial begin
    int seen;
    reset_n      = 1'b0;
    result_ready = 1'b0;
`ifdef SERIAL_DIVIDER_SIGNED_EN
    op_signed    = 1'b0;
`endif
    // First request is already presented while reset is held.
    dividend     = 32'd100;
    divisor      = 32'd7;
    start_valid  = 1'b1;

    #12;
    chk("reset quotient", 64'(quotient), 64'd0);
    chk("reset remainder", 64'(remainder), 64'd0);
    chk("reset flags", {61'd0, div_by_zero, result_valid, start_ready}, 64'b001);

    #10 reset_n = 1'b1;
    @(posedge clock); #1;
    start_valid = 1'b0;
    chk("accept after reset", {63'd0, start_ready}, 64'd0);
    wait_result("100/7", 32, 32'd14, 32'd2, 1'b0);
    handshake();

    do_start(32'h1234_5678, 32'd0);
    wait_result("div0", 1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    handshake();

    // Consumer stalls while a new request is offered and must be ignored.
    do_start(32'd1000, 32'd3);
    wait_result("1000/3", 32, 32'd333, 32'd1, 1'b0);
    dividend    = 32'd5;
    divisor     = 32'd5;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("stall quotient", 64'(quotient), 64'd333);
      chk("stall remainder", 64'(remainder), 64'd1);
      chk("stall valid/ready", {62'd0, result_valid, start_ready}, 64'b10);
    end
    handshake();
    @(posedge clock); #1;
    start_valid = 1'b0;
    chk("held request accepted", {63'd0, start_ready}, 64'd0);
    wait_result("5/5", 32, 32'd1, 32'd0, 1'b0);
    handshake();

    // Back-to-back: second request waits through the handshake edge.
    do_start(32'd50, 32'd5);
    wait_result("50/5", 32, 32'd10, 32'd0, 1'b0);
    dividend    = 32'd1;
    divisor     = 32'd1;
    start_valid = 1'b1;
    handshake();
    @(posedge clock); #1;
    start_valid = 1'b0;
    chk("back-to-back accept", {63'd0, start_ready}, 64'd0);
    wait_result("1/1", 32, 32'd1, 32'd0, 1'b0);
    handshake();

    // Reset mid-division abandons it.
    do_start(32'hFFFF_FFFF, 32'd3);
    repeat (10) begin
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    #1;
    chk("midreset quotient", 64'(quotient), 64'd0);
    chk("midreset remainder", 64'(remainder), 64'd0);
    chk("midreset flags", {61'd0, div_by_zero, result_valid, start_ready}, 64'b001);
    #2 reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (result_valid) seen++;
    end
    chk("no result after reset", 64'(seen), 64'd0);
    chk("idle after reset", {63'd0, start_ready}, 64'd1);

    do_start(32'hFFFF_FFFF, 32'd3);
    wait_result("ffffffff/3", 32, 32'h5555_5555, 32'd0, 1'b0);
    handshake();

    do_start(32'd7, 32'd9);
    wait_result("7/9", 32, 32'd0, 32'd7, 1'b0);
    handshake();

    do_start(32'hFFFF_FFFF, 32'd1);
    wait_result("ffffffff/1", 32, 32'hFFFF_FFFF, 32'd0, 1'b0);
    handshake();

`ifdef SERIAL_DIVIDER_SIGNED_EN
    op_signed = 1'b1;
    do_start(32'hFFFF_FFF9, 32'd2);
    wait_result("-7/2", 32, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    handshake();

    do_start(32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("min/-1", 32, 32'h8000_0000, 32'd0, 1'b0);
    handshake();

    do_start(32'hFFFF_FFF9, 32'd0);
    wait_result("signed div0", 1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    handshake();

    op_signed = 1'b0;
    do_start(32'hFFFF_FFF9, 32'd2);
    wait_result("unsigned fffffff9/2", 32, 32'h7FFF_FFFC, 32'd1, 1'b0);
    handshake();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
